// File: rtl/wb_gpio_ctrl.sv
// Wishbone-slave GPIO controller: OUT/OE/IEN registers, synchronised IN,
// sticky rising-edge STAT (W1C) and user_irq[0] = |(STAT & IEN).
// Optional feature macro: GPIO_TOGGLE_EN adds write-only TGL_LO/HI at 0x28/0x2C.
module wb_gpio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned N_IO      = 38
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [N_IO-1:0] io_in,
  output logic [N_IO-1:0] io_out,
  output logic [N_IO-1:0] io_oeb,
  output logic [2:0]      user_irq
);

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 6;

  logic [N_IO-1:0] out_q, out_d;
  logic [N_IO-1:0] oe_q, oe_d;
  logic [N_IO-1:0] ien_q, ien_d;
  logic [N_IO-1:0] stat_q, stat_d;
  logic [N_IO-1:0] s1_q, s1_d;
  logic [N_IO-1:0] s2_q, s2_d;
  logic [N_IO-1:0] s3_q, s3_d;
  logic            ack_q, ack_d;
  logic [AW-1:0]   dat_q, dat_d;

  logic            req;
  logic            wr;
  logic [IW-1:0]   idx;
  logic [31:0]     bmask;
  logic [N_IO-1:0] wmask;
  logic [N_IO-1:0] wdata;
  logic [N_IO-1:0] stat_clr;
  logic [N_IO-1:0] rsel;
  logic [63:0]     rwide;
  logic [31:0]     rdata;
  logic            unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // Bus decode, register next-state, read mux and input synchroniser
  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    ien_d    = ien_q;
    stat_clr = '0;
    rsel     = '0;

    req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    wr    = req & wbs_we_i;
    idx   = wbs_adr_i[7:2];
    bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    // Odd word index addresses the HI half; bits beyond N_IO fall away in the cast
    wmask = idx[0] ? N_IO'({bmask, 32'h0})     : N_IO'({32'h0, bmask});
    wdata = idx[0] ? N_IO'({wbs_dat_i, 32'h0}) : N_IO'({32'h0, wbs_dat_i});

    if (wr) begin
      case (idx[5:1])
        5'd0: out_d = (out_q & ~wmask) | (wdata & wmask);
        5'd1: oe_d  = (oe_q  & ~wmask) | (wdata & wmask);
        5'd3: ien_d = (ien_q & ~wmask) | (wdata & wmask);
        5'd4: stat_clr = wdata & wmask;
`ifdef GPIO_TOGGLE_EN
        5'd5: out_d = out_q ^ (wdata & wmask);
`endif
        default: ;
      endcase
    end

    // A fresh edge in the same cycle as a clear keeps the bit set
    stat_d = (stat_q & ~stat_clr) | (s2_q & ~s3_q);

    case (idx[5:1])
      5'd0: rsel = out_q;
      5'd1: rsel = oe_q;
      5'd2: rsel = s2_q;
      5'd3: rsel = ien_q;
      5'd4: rsel = stat_q;
      default: rsel = '0;
    endcase
    rwide = 64'(rsel);
    rdata = idx[0] ? rwide[63:32] : rwide[31:0];

    ack_d = req;
    dat_d = (req & ~wbs_we_i) ? rdata : 32'h0;

    s1_d = io_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q  <= '0;
      oe_q   <= '0;
      ien_q  <= '0;
      stat_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      ien_q  <= ien_d;
      stat_q <= stat_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = ~oe_q;
  assign user_irq  = {2'b00, |(stat_q & ien_q)};

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Scoreboarded bench for wb_gpio_ctrl with a register-table reference model.
module tb_wb_gpio_ctrl;

  localparam int unsigned N_IO = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [63:0] NMASK = (64'h1 << N_IO) - 64'h1;

  logic            clk = 1'b0;
  logic            rst;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     adr, dat_i;
  logic            ack;
  logic [31:0]     dat_o;
  logic [N_IO-1:0] io_in, io_out, io_oeb;
  logic [2:0]      irq;

  always #5 clk = ~clk;

  wb_gpio_ctrl #(.BASE_ADDR(BASE), .N_IO(N_IO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(irq)
  );

  typedef struct {bit rd; logic [31:0] exp;} exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain register contents, N_IO bits used
  logic [63:0] out_m, oe_m, ien_m, stat_m, in_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00: return out_m[31:0];
      8'h04: return out_m[63:32];
      8'h08: return oe_m[31:0];
      8'h0C: return oe_m[63:32];
      8'h10: return in_m[31:0];
      8'h14: return in_m[63:32];
      8'h18: return ien_m[31:0];
      8'h1C: return ien_m[63:32];
      8'h20: return stat_m[31:0];
      8'h24: return stat_m[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m32;
    logic [63:0] m, v;
    m32 = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m32 = m32 | (32'hFF << (8 * b));
    m = (off[2] ? {m32, 32'h0} : {32'h0, m32}) & NMASK;
    v = (off[2] ? {d, 32'h0} : {32'h0, d}) & m;
    case (off & 8'hF8)
      8'h00: out_m = (out_m & ~m) | v;
      8'h08: oe_m  = (oe_m & ~m) | v;
      8'h18: ien_m = (ien_m & ~m) | v;
      8'h20: stat_m = stat_m & ~v;
`ifdef GPIO_TOGGLE_EN
      8'h28: out_m = out_m ^ v;
`endif
      default: ;
    endcase
  endtask

  task automatic check_pins();
    check("io_out", 64'(io_out), out_m);
    check("io_oeb", 64'(io_oeb), ~oe_m & NMASK);
    check("user_irq", 64'(irq), {63'h0, |(stat_m & ien_m)});
  endtask

  // Called at a negedge; returns at a negedge
  task automatic xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] s, input logic in_win);
    exp_t e;
    logic got;
    got = 1'b0;
    if (in_win) begin
      e.rd = !w;
      e.exp = model_read(off);
      sbq.push_back(e);
    end
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = d;
    adr = in_win ? (BASE + 32'(off)) : (BASE + 32'h100 + 32'(off));
    if (in_win) begin
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge clk); #1;
        got = ack;
      end
      check("ack_arrives", 64'(got), 64'h1);
      if (w) model_write(off, d, s);
    end else begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (ack) got = 1'b1;
      end
      check("no_ack_out_of_window", 64'(got), 64'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_io(input logic [63:0] v);
    io_in = v[N_IO-1:0];
    repeat (5) @(negedge clk);
    stat_m = stat_m | (v & ~in_m & NMASK);
    in_m = v & NMASK;
  endtask

  // Monitor: pops an expectation on each ack and checks read data and idle bus
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ack_prev = 1'b0;
    end else begin
      if (ack) begin
        check("ack_single_cycle", 64'(ack_prev), 64'h0);
        check("ack_expected", 64'(sbq.size() != 0), 64'h1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          if (e.rd) check("read_data", 64'(dat_o), 64'(e.exp));
        end
      end else if (dat_o !== 32'h0) begin
        check("dat_idle_zero", 64'(dat_o), 64'h0);
      end
      ack_prev = ack;
    end
  end

  initial begin
    logic [7:0] off;
    logic [63:0] v;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_i = 32'h0; io_in = '0;
    out_m = '0; oe_m = '0; ien_m = '0; stat_m = '0; in_m = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state: pins and every offset read 0
    check_pins();
    for (int i = 0; i < 16; i++) xfer(1'b0, 8'(i * 4), 32'h0, 4'hF, 1'b1);

    // Byte-enabled writes to OE_LO / OUT_LO
    xfer(1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF, 1'b1);
    xfer(1'b1, 8'h00, 32'hA5A5_A5A5, 4'b0011, 1'b1);
    check_pins();
    check("io_out_lo_a5a5", 64'(io_out[31:0]), 64'h0000_A5A5);

    // HI register width clipping
    xfer(1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b1);
    xfer(1'b0, 8'h04, 32'h0, 4'hF, 1'b1);

    // Rising edge on io_in[5], interrupt, then W1C
    xfer(1'b1, 8'h18, 32'h20, 4'hF, 1'b1);
    set_io(64'h20);
    check_pins();
    xfer(1'b0, 8'h20, 32'h0, 4'hF, 1'b1);
    xfer(1'b1, 8'h20, 32'h20, 4'hF, 1'b1);
    check_pins();

    // Clear coinciding with a fresh edge: set wins
    set_io(64'h0);
    io_in = N_IO'(64'h20);
    @(negedge clk);
    @(negedge clk);
    xfer(1'b1, 8'h20, 32'h20, 4'hF, 1'b1);
    stat_m = stat_m | 64'h20;
    in_m = 64'h20;
    check_pins();
    xfer(1'b0, 8'h20, 32'h0, 4'hF, 1'b1);

    // Toggle register (or unmapped slot without the feature)
    xfer(1'b1, 8'h00, 32'h0F, 4'hF, 1'b1);
    xfer(1'b1, 8'h28, 32'hFF, 4'hF, 1'b1);
    xfer(1'b0, 8'h00, 32'h0, 4'hF, 1'b1);
    xfer(1'b0, 8'h28, 32'h0, 4'hF, 1'b1);

    // Out-of-window access: no ack, no change
    xfer(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 4'hF, 1'b1);
    check_pins();

    // Randomised traffic including unmapped offsets and io_in activity
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        v = {$urandom, $urandom};
        set_io(v);
      end else begin
        off = 8'($urandom_range(0, 15) * 4);
        xfer(1'($urandom_range(0, 1)), off, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      end
      check_pins();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
